// File: rtl/usb_diff_rx_ctrl.sv
// Power-up sequencer and line-state monitor for the USB differential receiver primitive.
// Optional macro USB_DIFF_RX_CTRL_FILTER_EN adds a 3-sample majority filter on the synchronised lines.
module usb_diff_rx_ctrl #(
  parameter int unsigned CalibW        = 32,
  parameter int unsigned SettleCycles  = 16,
  parameter int unsigned ResetCycles   = 48,
  parameter int unsigned SuspendCycles = 96
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              lowspeed_i,
  input  logic              core_pok_i,
  input  logic [CalibW-1:0] calib_i,
  input  logic              calib_load_i,
  input  logic              rx_d_i,
  input  logic              rx_dp_i,
  input  logic              rx_dn_i,
  output logic [CalibW-1:0] calibration_o,
  output logic              pullup_p_en_o,
  output logic              pullup_n_en_o,
  output logic              input_en_o,
  output logic              ready_o,
  output logic              rx_d_o,
  output logic [1:0]        line_state_o,
  output logic              bus_reset_o,
  output logic              suspend_o
);

  localparam int unsigned SetW = $clog2(SettleCycles + 1);
  localparam int unsigned RstW = $clog2(ResetCycles + 1);
  localparam int unsigned SusW = $clog2(SuspendCycles + 1);
  localparam logic [SetW-1:0] SetLast = SetW'(SettleCycles - 1);
  localparam logic [RstW-1:0] RstMax  = RstW'(ResetCycles);
  localparam logic [SusW-1:0] SusMax  = SusW'(SuspendCycles);

  typedef enum logic [2:0] {
    StOff    = 3'd0,
    StCal    = 3'd1,
    StPullup = 3'd2,
    StInen   = 3'd3,
    StActive = 3'd4
  } state_e;

  // Line code 01 is always J; low-speed swaps which wire idles high.
  function automatic logic [1:0] decode_line(input logic dp, input logic dn, input logic ls);
    logic [1:0] code;
    if (ls) begin
      code = {dp, dn};
    end else begin
      code = {dn, dp};
    end
    return code;
  endfunction

  function automatic logic [2:0] maj3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_e             state_q, state_d;
  logic [SetW-1:0]    set_cnt_q, set_cnt_d;
  logic [RstW-1:0]    se0_cnt_q, se0_cnt_d;
  logic [SusW-1:0]    j_cnt_q, j_cnt_d;
  logic [CalibW-1:0]  calib_q, calib_d;
  logic               ls_q, ls_d;
  logic               pull_p_q, pull_p_d, pull_n_q, pull_n_d;
  logic               inen_q, inen_d, ready_q, ready_d;
  logic               rx_d_q, rx_d_d;
  logic [1:0]         line_q, line_d;
  logic               bus_reset_q, bus_reset_d;
  logic               suspend_q, suspend_d;
  logic [2:0]         sync1_q;
  logic [2:0]         line_src_s;
  logic               go_s, active_s, cnt_run_s;

  assign go_s = enable_i & core_pok_i;

  // Sequencer next state; loss of enable or power wins over any advance.
  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    if (!go_s) begin
      state_d   = StOff;
      set_cnt_d = {SetW{1'b0}};
    end else begin
      case (state_q)
        StOff: begin
          state_d   = StCal;
          set_cnt_d = {SetW{1'b0}};
        end
        StCal: begin
          state_d   = StPullup;
          set_cnt_d = {SetW{1'b0}};
        end
        StPullup: begin
          if (set_cnt_q == SetLast) begin
            state_d   = StInen;
            set_cnt_d = {SetW{1'b0}};
          end else begin
            set_cnt_d = set_cnt_q + SetW'(1);
          end
        end
        StInen: begin
          if (set_cnt_q == SetLast) begin
            state_d   = StActive;
            set_cnt_d = {SetW{1'b0}};
          end else begin
            set_cnt_d = set_cnt_q + SetW'(1);
          end
        end
        StActive: begin
          state_d   = StActive;
          set_cnt_d = {SetW{1'b0}};
        end
        default: begin
          state_d   = StOff;
          set_cnt_d = {SetW{1'b0}};
        end
      endcase
    end
  end

  // Enables follow the next state so they change on the same edge as the FSM.
  always_comb begin
    ls_d    = ls_q;
    calib_d = calib_q;
    if ((state_q == StOff) && go_s) begin
      ls_d = lowspeed_i;
    end else begin
      ls_d = ls_q;
    end
    if ((state_q == StOff) && calib_load_i) begin
      calib_d = calib_i;
    end else begin
      calib_d = calib_q;
    end
    active_s = (state_d == StActive);
    pull_p_d = ((state_d == StPullup) || (state_d == StInen) || active_s) & ~ls_d;
    pull_n_d = ((state_d == StPullup) || (state_d == StInen) || active_s) & ls_d;
    inen_d   = (state_d == StInen) || active_s;
    ready_d  = active_s;
  end

`ifdef USB_DIFF_RX_CTRL_FILTER_EN
  logic [2:0] sync2_q, sync3_q, sync4_q;

  // Synchroniser followed by a three-deep history for the majority vote.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      sync3_q <= 3'b000;
      sync4_q <= 3'b000;
    end else begin
      sync1_q <= {rx_d_i, rx_dp_i, rx_dn_i};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      sync4_q <= sync3_q;
    end
  end

  assign line_src_s = maj3(sync2_q, sync3_q, sync4_q);
`else
  // First synchroniser stage; the output registers form the second stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 3'b000;
    end else begin
      sync1_q <= {rx_d_i, rx_dp_i, rx_dn_i};
    end
  end

  assign line_src_s = sync1_q;
`endif

  // Line decode and the SE0 / idle-J run counters, active only while ACTIVE persists.
  always_comb begin
    rx_d_d    = 1'b0;
    line_d    = 2'b00;
    se0_cnt_d = {RstW{1'b0}};
    j_cnt_d   = {SusW{1'b0}};
    cnt_run_s = (state_q == StActive) && (state_d == StActive);
    if (state_d == StActive) begin
      rx_d_d = line_src_s[2];
      line_d = decode_line(line_src_s[1], line_src_s[0], ls_d);
    end else begin
      rx_d_d = 1'b0;
      line_d = 2'b00;
    end
    if (cnt_run_s && (line_q == 2'b00)) begin
      se0_cnt_d = (se0_cnt_q == RstMax) ? se0_cnt_q : se0_cnt_q + RstW'(1);
    end else begin
      se0_cnt_d = {RstW{1'b0}};
    end
    if (cnt_run_s && (line_q == 2'b01)) begin
      j_cnt_d = (j_cnt_q == SusMax) ? j_cnt_q : j_cnt_q + SusW'(1);
    end else begin
      j_cnt_d = {SusW{1'b0}};
    end
    bus_reset_d = cnt_run_s && (se0_cnt_d == RstMax) && (se0_cnt_q != RstMax);
    suspend_d   = cnt_run_s && (j_cnt_d == SusMax);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StOff;
      set_cnt_q   <= {SetW{1'b0}};
      se0_cnt_q   <= {RstW{1'b0}};
      j_cnt_q     <= {SusW{1'b0}};
      calib_q     <= {CalibW{1'b0}};
      ls_q        <= 1'b0;
      pull_p_q    <= 1'b0;
      pull_n_q    <= 1'b0;
      inen_q      <= 1'b0;
      ready_q     <= 1'b0;
      rx_d_q      <= 1'b0;
      line_q      <= 2'b00;
      bus_reset_q <= 1'b0;
      suspend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_cnt_q   <= set_cnt_d;
      se0_cnt_q   <= se0_cnt_d;
      j_cnt_q     <= j_cnt_d;
      calib_q     <= calib_d;
      ls_q        <= ls_d;
      pull_p_q    <= pull_p_d;
      pull_n_q    <= pull_n_d;
      inen_q      <= inen_d;
      ready_q     <= ready_d;
      rx_d_q      <= rx_d_d;
      line_q      <= line_d;
      bus_reset_q <= bus_reset_d;
      suspend_q   <= suspend_d;
    end
  end

  assign calibration_o = calib_q;
  assign pullup_p_en_o = pull_p_q;
  assign pullup_n_en_o = pull_n_q;
  assign input_en_o    = inen_q;
  assign ready_o       = ready_q;
  assign rx_d_o        = rx_d_q;
  assign line_state_o  = line_q;
  assign bus_reset_o   = bus_reset_q;
  assign suspend_o     = suspend_q;

endmodule

// File: tb/tb_usb_diff_rx_ctrl.sv
// Self-checking bench for usb_diff_rx_ctrl with a history-based reference model of the line monitor.
module tb_usb_diff_rx_ctrl;
  localparam int CW   = 32;
  localparam int SET  = 4;
  localparam int RST  = 8;
  localparam int SUS  = 12;
  localparam int BIG  = 1 << 30;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic rst_n, enable, lowspeed, core_pok, calib_load, rx_d, rx_dp, rx_dn;
  logic [CW-1:0] calib;
  logic [CW-1:0] calibration;
  logic pull_p, pull_n, inen, ready, rxd_o, bus_reset, suspend;
  logic [1:0] line_state;

  int errors = 0;
  int checks = 0;
  int t = 0;
  int act_start = BIG;
  logic ls_m = 1'b0;
  logic [CW-1:0] last_cal;
  logic in_dp [HMAX];
  logic in_dn [HMAX];
  logic in_d  [HMAX];

  usb_diff_rx_ctrl #(.CalibW(CW), .SettleCycles(SET), .ResetCycles(RST), .SuspendCycles(SUS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .lowspeed_i(lowspeed), .core_pok_i(core_pok),
    .calib_i(calib), .calib_load_i(calib_load), .rx_d_i(rx_d), .rx_dp_i(rx_dp), .rx_dn_i(rx_dn),
    .calibration_o(calibration), .pullup_p_en_o(pull_p), .pullup_n_en_o(pull_n), .input_en_o(inen),
    .ready_o(ready), .rx_d_o(rxd_o), .line_state_o(line_state), .bus_reset_o(bus_reset),
    .suspend_o(suspend)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at interval %0d", t);
    $fatal(1, "timeout");
  end

  // Record the inputs of the current interval, then advance to just after the next edge.
  task automatic tick();
    if (t < HMAX) begin
      in_dp[t] = rx_dp;
      in_dn[t] = rx_dn;
      in_d[t]  = rx_d;
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  // Expected line code in interval k: inputs from two intervals earlier, J meaning the idle-high wire.
  function automatic logic [1:0] exp_ls(int k);
    logic dp, dn;
    if (k < act_start || k < 2 || k - 2 >= HMAX) return 2'b00;
    dp = in_dp[k-2];
    dn = in_dn[k-2];
    if (dp == dn) return {dp, dn};
    if (ls_m ? dn : dp) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic exp_rxd(int k);
    if (k < act_start || k < 2 || k - 2 >= HMAX) return 1'b0;
    return in_d[k-2];
  endfunction

  // Number of consecutive intervals before k (since ACTIVE began) showing the given code.
  function automatic int run_len(int k, logic [1:0] code);
    int n = 0;
    for (int j = k - 1; j >= act_start && n < 200; j--) begin
      if (exp_ls(j) == code) n++;
      else break;
    end
    return n;
  endfunction

  function automatic logic exp_bus_reset(int k);
    return (k >= act_start) && (run_len(k, 2'b00) == RST);
  endfunction

  function automatic logic exp_suspend(int k);
    return (k >= act_start) && (run_len(k, 2'b01) >= SUS);
  endfunction

  task automatic set_code(int code);
    case (code)
      0: begin rx_dp = 1'b0; rx_dn = 1'b0; end
      1: begin rx_dp = ~ls_m; rx_dn = ls_m; end
      2: begin rx_dp = ls_m; rx_dn = ~ls_m; end
      default: begin rx_dp = 1'b1; rx_dn = 1'b1; end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; core_pok = 1'b1; lowspeed = 1'b0;
    calib = 32'h1234_5678; calib_load = 1'b1; rx_d = 1'b1; rx_dp = 1'b1; rx_dn = 1'b0;
    #2;
    checks++;
    if ({calibration, pull_p, pull_n, inen, ready, rxd_o, line_state, bus_reset, suspend} !== 41'd0) begin
      errors++;
      $display("FAIL reset_initial: outputs=%h required 0",
               {calibration, pull_p, pull_n, inen, ready, rxd_o, line_state, bus_reset, suspend});
    end
    repeat (3) tick();
    checks++;
    if ({calibration, pull_p, pull_n, inen, ready, rxd_o, line_state, bus_reset, suspend} !== 41'd0) begin
      errors++;
      $display("FAIL reset_held: outputs=%h required 0",
               {calibration, pull_p, pull_n, inen, ready, rxd_o, line_state, bus_reset, suspend});
    end
    enable = 1'b0; calib_load = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_calib_off();
    logic [CW-1:0] v;
    calib = 32'hA5A5_0001; calib_load = 1'b1;
    tick();
    calib_load = 1'b0;
    checks++;
    if (calibration !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL calib_load_off: got %h required a5a50001", calibration);
    end
    v = $urandom;
    calib = v; calib_load = 1'b1;
    tick();
    calib_load = 1'b0; calib = ~v;
    tick();
    checks++;
    if (calibration !== v) begin
      errors++;
      $display("FAIL calib_load_random: got %h required %h", calibration, v);
    end
  endtask

  task automatic test_powerup();
    int t0;
    logic [CW-1:0] v;
    v = $urandom;
    calib = v; calib_load = 1'b1; enable = 1'b1; core_pok = 1'b1; lowspeed = 1'b0;
    rx_dp = 1'b0; rx_dn = 1'b1; rx_d = 1'b0;
    t0 = t;
    ls_m = 1'b0;
    act_start = t0 + 10;
    tick();
    calib_load = 1'b0;
    last_cal = v;
    checks++;
    if (calibration !== v) begin
      errors++;
      $display("FAIL calib_same_cycle: got %h required %h", calibration, v);
    end
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if ({pull_p, pull_n, inen, ready} !== {(k >= 2), 1'b0, (k >= 6), (k >= 10)}) begin
        errors++;
        $display("FAIL powerup_seq cycle %0d: p/n/inen/ready=%b required %b", k,
                 {pull_p, pull_n, inen, ready}, {(k >= 2), 1'b0, (k >= 6), (k >= 10)});
      end
      tick();
    end
  endtask

  task automatic test_calib_active();
    calib = ~last_cal; calib_load = 1'b1;
    tick();
    calib_load = 1'b0;
    tick();
    checks++;
    if (calibration !== last_cal) begin
      errors++;
      $display("FAIL calib_ignored_active: got %h required %h", calibration, last_cal);
    end
  endtask

  task automatic test_bus_reset();
    int s, pulses, pos;
    set_code(1);
    repeat (3) tick();
    s = t; pulses = 0; pos = -1;
    set_code(0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_reset === 1'b1) begin pulses++; pos = t - s; end
      checks++;
      if (bus_reset !== exp_bus_reset(t)) begin
        errors++;
        $display("FAIL bus_reset_long @%0d: got %b required %b", t - s, bus_reset, exp_bus_reset(t));
      end
    end
    checks++;
    if (pulses !== 1 || pos !== 10) begin
      errors++;
      $display("FAIL bus_reset_pulse: pulses=%0d at %0d required 1 at 10", pulses, pos);
    end
    set_code(1);
    repeat (4) tick();
    pulses = 0;
    set_code(0);
    repeat (7) tick();
    if (bus_reset === 1'b1) pulses++;
    set_code(1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus_reset === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL bus_reset_short: pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_suspend();
    int s;
    set_code(2);
    repeat (3) tick();
    s = t;
    set_code(1);
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (suspend !== exp_suspend(t)) begin
        errors++;
        $display("FAIL suspend_model @%0d: got %b required %b", t - s, suspend, exp_suspend(t));
      end
      if (t - s == 13 || t - s == 14) begin
        checks++;
        if (suspend !== (t - s == 14)) begin
          errors++;
          $display("FAIL suspend_edge @%0d: got %b required %b", t - s, suspend, (t - s == 14));
        end
      end
    end
    set_code(2);
    s = t;
    repeat (3) tick();
    checks++;
    if ({suspend, line_state} !== 3'b010) begin
      errors++;
      $display("FAIL suspend_clear: suspend/line=%b required 010", {suspend, line_state});
    end
  endtask

  task automatic test_random(int cycles);
    int n = 0;
    int code, len;
    while (n < cycles) begin
      code = $urandom_range(0, 3);
      len  = (code == 1) ? $urandom_range(1, 16) : $urandom_range(1, 11);
      set_code(code);
      for (int i = 0; i < len; i++) begin
        rx_d = $urandom_range(0, 1);
        tick();
        n++;
        checks++;
        if ({rxd_o, line_state, bus_reset, suspend} !==
            {exp_rxd(t), exp_ls(t), exp_bus_reset(t), exp_suspend(t)}) begin
          errors++;
          $display("FAIL random_line @%0d: rxd/ls/rst/sus=%b required %b", t,
                   {rxd_o, line_state, bus_reset, suspend},
                   {exp_rxd(t), exp_ls(t), exp_bus_reset(t), exp_suspend(t)});
        end
      end
    end
  endtask

  task automatic test_lowspeed();
    int t0;
    enable = 1'b0;
    tick();
    act_start = BIG;
    checks++;
    if ({pull_p, pull_n, inen, ready, line_state} !== 6'd0) begin
      errors++;
      $display("FAIL disable_off: p/n/inen/ready/line=%b required 0", {pull_p, pull_n, inen, ready, line_state});
    end
    lowspeed = 1'b1; enable = 1'b1;
    t0 = t;
    tick();
    lowspeed = 1'b0;
    ls_m = 1'b1;
    act_start = t0 + 10;
    repeat (11) tick();
    checks++;
    if ({pull_p, pull_n, ready} !== 3'b011) begin
      errors++;
      $display("FAIL lowspeed_pullup: p/n/ready=%b required 011", {pull_p, pull_n, ready});
    end
    rx_dp = 1'b0; rx_dn = 1'b1;
    repeat (3) tick();
    checks++;
    if (line_state !== 2'b01) begin
      errors++;
      $display("FAIL lowspeed_j: got %b required 01", line_state);
    end
    rx_dp = 1'b1; rx_dn = 1'b0;
    repeat (3) tick();
    checks++;
    if (line_state !== 2'b10) begin
      errors++;
      $display("FAIL lowspeed_k: got %b required 10", line_state);
    end
    test_random(200);
  endtask

  task automatic test_pok_drop();
    int t0, t1;
    enable = 1'b0;
    tick();
    act_start = BIG;
    lowspeed = 1'b0; enable = 1'b1; core_pok = 1'b1;
    t0 = t;
    tick();
    ls_m = 1'b0;
    repeat (6) tick();
    checks++;
    if ({pull_p, inen, ready} !== 3'b110) begin
      errors++;
      $display("FAIL pok_pre_inen: p/inen/ready=%b required 110", {pull_p, inen, ready});
    end
    core_pok = 1'b0;
    tick();
    checks++;
    if ({pull_p, pull_n, inen, ready, rxd_o, line_state} !== 7'd0) begin
      errors++;
      $display("FAIL pok_drop_off: p/n/inen/ready/rxd/line=%b required 0",
               {pull_p, pull_n, inen, ready, rxd_o, line_state});
    end
    core_pok = 1'b1;
    t1 = t;
    act_start = t1 + 10;
    tick();
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if ({pull_p, inen, ready} !== {(k >= 2), (k >= 6), (k >= 10)}) begin
        errors++;
        $display("FAIL pok_restart cycle %0d: p/inen/ready=%b required %b", k,
                 {pull_p, inen, ready}, {(k >= 2), (k >= 6), (k >= 10)});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_calib_off();
    test_powerup();
    test_calib_active();
    test_bus_reset();
    test_suspend();
    test_random(300);
    test_lowspeed();
    test_pok_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
